// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: accepts one instruction at a time from execute,
// issues aligned loads/stores on the data-memory bus, waits for ack or
// timeout, and forwards results to writeback.
module memory_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] brnch,
    input  logic        zero,
    input  logic [31:0] ALUresult,
    input  logic [31:0] rdData2,
    input  logic [4:0]  writeReg,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] branchTarget,
    output logic        valid_out,
    output logic [31:0] readData,
    output logic [31:0] ALUresultMEM,
    output logic [4:0]  writeRegMEM,
    output logic        RegWriteMEM,
    output logic        MemtoRegMEM,
    memory_stage_if.master dmem,
    output logic        align_err,
    output logic        bus_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    // Last WAIT cycle without ack: the request has then been held TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pcsrc_q;
    logic [31:0]     branch_target_q;
    logic            valid_out_q;
    logic [31:0]     read_data_q;
    logic [31:0]     alu_result_q;
    logic [4:0]      write_reg_q;
    logic            reg_write_q;
    logic            mem_to_reg_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            align_err_q;
    logic            bus_err_q;

    logic            accept;
    logic            mem_op;
    logic            aligned;
    logic            go_mem;
    logic            misaligned;
    logic            ack_seen;
    logic            timed_out;

    assign accept     = (state_q == IDLE) && valid_in;
    assign mem_op     = MemRead || MemWrite;
    assign aligned    = (ALUresult[1:0] == 2'b00);
    assign go_mem     = accept && mem_op && aligned;
    assign misaligned = accept && mem_op && !aligned;
    // Ack only counts while a request is outstanding, i.e. in WAIT.
    assign ack_seen   = (state_q == WAIT) && dmem.dmem_ack;
    // Ack in the final cycle takes priority over the timeout.
    assign timed_out  = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == CNT_LAST);

    // State and wait-cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; counter is zero in IDLE so it starts clear on WAIT entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (go_mem) state_d = WAIT;
            end
            WAIT: begin
                if (ack_seen || timed_out) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: upstream is held for the whole outstanding request.
    always_comb begin
        stall = (state_q == WAIT);
    end

    // Datapath: capture on acceptance, complete on ack, abort on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcsrc_q         <= 1'b0;
            branch_target_q <= '0;
            valid_out_q     <= 1'b0;
            read_data_q     <= '0;
            alu_result_q    <= '0;
            write_reg_q     <= '0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            align_err_q     <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            pcsrc_q     <= 1'b0;
            valid_out_q <= 1'b0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;

            if (accept) begin
                if (Branch) begin
                    pcsrc_q         <= zero;
                    branch_target_q <= brnch;
                end
                alu_result_q <= ALUresult;
                write_reg_q  <= writeReg;
                reg_write_q  <= RegWrite;
                mem_to_reg_q <= MemtoReg;
                if (!mem_op) valid_out_q <= 1'b1;
                if (misaligned) align_err_q <= 1'b1;
                if (go_mem) begin
                    req_q   <= 1'b1;
                    we_q    <= MemWrite;
                    addr_q  <= ALUresult;
                    wdata_q <= rdData2;
                end
            end

            if (ack_seen) begin
                req_q       <= 1'b0;
                we_q        <= 1'b0;
                valid_out_q <= 1'b1;
                if (!we_q) read_data_q <= dmem.dmem_rdata;
            end else if (timed_out) begin
                req_q     <= 1'b0;
                we_q      <= 1'b0;
                bus_err_q <= 1'b1;
            end
        end
    end

    assign PCSrc           = pcsrc_q;
    assign branchTarget    = branch_target_q;
    assign valid_out       = valid_out_q;
    assign readData        = read_data_q;
    assign ALUresultMEM    = alu_result_q;
    assign writeRegMEM     = write_reg_q;
    assign RegWriteMEM     = reg_write_q;
    assign MemtoRegMEM     = mem_to_reg_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign align_err       = align_err_q;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] brnch;
    logic        zero;
    logic [31:0] ALUresult;
    logic [31:0] rdData2;
    logic [4:0]  writeReg;
    logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
    logic        stall, PCSrc, valid_out;
    logic [31:0] branchTarget, readData, ALUresultMEM;
    logic [4:0]  writeRegMEM;
    logic        RegWriteMEM, MemtoRegMEM;
    logic        align_err, bus_err;

    int unsigned n_cmp;
    int unsigned n_err;

    memory_stage_if dbus ();

    memory_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .brnch        (brnch),
        .zero         (zero),
        .ALUresult    (ALUresult),
        .rdData2      (rdData2),
        .writeReg     (writeReg),
        .Branch       (Branch),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .branchTarget (branchTarget),
        .valid_out    (valid_out),
        .readData     (readData),
        .ALUresultMEM (ALUresultMEM),
        .writeRegMEM  (writeRegMEM),
        .RegWriteMEM  (RegWriteMEM),
        .MemtoRegMEM  (MemtoRegMEM),
        .dmem         (dbus),
        .align_err    (align_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in  = 1'b0;
        brnch     = '0;
        zero      = 1'b0;
        ALUresult = '0;
        rdData2   = '0;
        writeReg  = '0;
        Branch    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        dbus.dmem_ack   = 1'b0;
        dbus.dmem_rdata = '0;
        rst = 1'b1;

        // Reset, with a valid instruction presented during reset.
        valid_in  = 1'b1;
        ALUresult = 32'h0000_0077;
        writeReg  = 5'd9;
        tick();
        tick();
        clear_inputs();
        rst = 1'b0;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_req", 32'(dbus.dmem_req), 32'd0);
        check("rst_we", 32'(dbus.dmem_we), 32'd0);
        check("rst_addr", dbus.dmem_addr, 32'd0);
        check("rst_wdata", dbus.dmem_wdata, 32'd0);
        check("rst_alu", ALUresultMEM, 32'd0);
        check("rst_wreg", 32'(writeRegMEM), 32'd0);
        check("rst_btgt", branchTarget, 32'd0);
        check("rst_rdata", readData, 32'd0);
        tick();
        check("rst_vin_ignored", 32'(valid_out), 32'd0);

        // Load with ack in the third WAIT cycle.
        valid_in  = 1'b1;
        MemRead   = 1'b1;
        ALUresult = 32'h0000_0100;
        writeReg  = 5'd5;
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        tick();
        clear_inputs();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall) n++;
            check("ld_req", 32'(dbus.dmem_req), 32'd1);
            check("ld_addr", dbus.dmem_addr, 32'h0000_0100);
            check("ld_we", 32'(dbus.dmem_we), 32'd0);
            if (i == 2) begin
                dbus.dmem_ack   = 1'b1;
                dbus.dmem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        dbus.dmem_ack = 1'b0;
        check("ld_stall_cycles", 32'(n), 32'd3);
        check("ld_stall_done", 32'(stall), 32'd0);
        check("ld_req_drop", 32'(dbus.dmem_req), 32'd0);
        check("ld_valid", 32'(valid_out), 32'd1);
        check("ld_rdata", readData, 32'hDEAD_BEEF);
        check("ld_wreg", 32'(writeRegMEM), 32'd5);
        check("ld_regwrite", 32'(RegWriteMEM), 32'd1);
        check("ld_memtoreg", 32'(MemtoRegMEM), 32'd1);
        tick();
        check("ld_valid_pulse", 32'(valid_out), 32'd0);

        // Store acked in the first WAIT cycle; readData must not change.
        valid_in  = 1'b1;
        MemWrite  = 1'b1;
        ALUresult = 32'h0000_0204;
        rdData2   = 32'h1234_5678;
        tick();
        clear_inputs();
        check("st_stall", 32'(stall), 32'd1);
        check("st_req", 32'(dbus.dmem_req), 32'd1);
        check("st_we", 32'(dbus.dmem_we), 32'd1);
        check("st_addr", dbus.dmem_addr, 32'h0000_0204);
        check("st_wdata", dbus.dmem_wdata, 32'h1234_5678);
        dbus.dmem_ack   = 1'b1;
        dbus.dmem_rdata = 32'h0000_0055;
        tick();
        dbus.dmem_ack = 1'b0;
        check("st_stall_done", 32'(stall), 32'd0);
        check("st_valid", 32'(valid_out), 32'd1);
        check("st_we_drop", 32'(dbus.dmem_we), 32'd0);
        check("st_rdata_hold", readData, 32'hDEAD_BEEF);
        tick();
        check("st_valid_pulse", 32'(valid_out), 32'd0);

        // Misaligned load.
        valid_in  = 1'b1;
        MemRead   = 1'b1;
        ALUresult = 32'h0000_0102;
        tick();
        clear_inputs();
        check("mis_req", 32'(dbus.dmem_req), 32'd0);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_align", 32'(align_err), 32'd1);
        check("mis_valid", 32'(valid_out), 32'd0);
        tick();
        check("mis_align_pulse", 32'(align_err), 32'd0);
        check("mis_valid2", 32'(valid_out), 32'd0);

        // Timeout: no ack at all.
        valid_in  = 1'b1;
        MemRead   = 1'b1;
        ALUresult = 32'h0000_0300;
        tick();
        clear_inputs();
        n = 0;
        while (dbus.dmem_req && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd16);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_valid", 32'(valid_out), 32'd0);
        check("to_stall", 32'(stall), 32'd0);
        valid_in  = 1'b1;
        ALUresult = 32'h0000_0abc;
        writeReg  = 5'd7;
        tick();
        clear_inputs();
        check("to_bus_err_pulse", 32'(bus_err), 32'd0);
        check("to_next_valid", 32'(valid_out), 32'd1);
        check("to_next_alu", ALUresultMEM, 32'h0000_0abc);

        // Ack in the very cycle the timeout would fire: ack wins.
        valid_in  = 1'b1;
        MemRead   = 1'b1;
        ALUresult = 32'h0000_0400;
        tick();
        clear_inputs();
        for (int i = 0; i < 15; i++) tick();
        check("edge_req_held", 32'(dbus.dmem_req), 32'd1);
        dbus.dmem_ack   = 1'b1;
        dbus.dmem_rdata = 32'hCAFE_F00D;
        tick();
        dbus.dmem_ack = 1'b0;
        check("edge_valid", 32'(valid_out), 32'd1);
        check("edge_bus_err", 32'(bus_err), 32'd0);
        check("edge_rdata", readData, 32'hCAFE_F00D);
        tick();
        check("edge_bus_err2", 32'(bus_err), 32'd0);

        // Taken branch followed by four back-to-back R-type instructions.
        valid_in  = 1'b1;
        Branch    = 1'b1;
        zero      = 1'b1;
        brnch     = 32'h0000_0040;
        ALUresult = 32'h0000_0011;
        writeReg  = 5'd1;
        RegWrite  = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_out) n++;
            check("br_alu", ALUresultMEM, (i == 0) ? 32'h0000_0011 : 32'h0000_0020 + 32'(i));
            check("br_pcsrc", 32'(PCSrc), (i == 0) ? 32'd1 : 32'd0);
            check("br_tgt", branchTarget, 32'h0000_0040);
            Branch    = 1'b0;
            zero      = 1'b0;
            ALUresult = 32'h0000_0021 + 32'(i);
            writeReg  = 5'(i + 2);
        end
        clear_inputs();
        check("br_valid_run", 32'(n), 32'd5);
        tick();
        check("br_valid_end", 32'(valid_out), 32'd0);

        // Not-taken branch: no PCSrc, target still captured.
        valid_in = 1'b1;
        Branch   = 1'b1;
        zero     = 1'b0;
        brnch    = 32'h0000_0080;
        tick();
        clear_inputs();
        check("nt_pcsrc", 32'(PCSrc), 32'd0);
        check("nt_tgt", branchTarget, 32'h0000_0080);

        // Ack with no outstanding request is ignored.
        tick();
        dbus.dmem_ack   = 1'b1;
        dbus.dmem_rdata = 32'h0000_0999;
        tick();
        dbus.dmem_ack = 1'b0;
        check("idle_ack_valid", 32'(valid_out), 32'd0);
        check("idle_ack_rdata", readData, 32'hCAFE_F00D);

        // Reset in the second WAIT cycle, ack arriving afterwards.
        valid_in  = 1'b1;
        MemRead   = 1'b1;
        ALUresult = 32'h0000_0500;
        writeReg  = 5'd3;
        tick();
        clear_inputs();
        tick();
        check("rw_stall_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_req", 32'(dbus.dmem_req), 32'd0);
        check("rw_stall", 32'(stall), 32'd0);
        check("rw_valid", 32'(valid_out), 32'd0);
        check("rw_bus_err", 32'(bus_err), 32'd0);
        check("rw_rdata", readData, 32'd0);
        check("rw_alu", ALUresultMEM, 32'd0);
        check("rw_tgt", branchTarget, 32'd0);
        dbus.dmem_ack   = 1'b1;
        dbus.dmem_rdata = 32'h0000_0BAD;
        tick();
        dbus.dmem_ack = 1'b0;
        check("rw_late_valid", 32'(valid_out), 32'd0);
        check("rw_late_rdata", readData, 32'd0);
        check("rw_late_stall", 32'(stall), 32'd0);
        tick();
        check("rw_late_bus_err", 32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles dmem_req is held without dmem_ack before abort.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  execute stage presents a valid instruction.
REQ-005 brnch  input  32  branch target from execute.
REQ-006 zero  input  1  ALU zero flag from execute.
REQ-007 ALUresult  input  32  ALU result; byte address for loads/stores.
REQ-008 rdData2  input  32  store data.
REQ-009 writeReg  input  5  destination register number.
REQ-010 Branch, MemRead, MemWrite, RegWrite, MemtoReg  input  1 each  control bits carried from decode.
REQ-011 stall  output  1  upstream must hold inputs; valid_in ignored while high.
REQ-012 PCSrc  output  1  take branch.
REQ-013 branchTarget  output  32  registered copy of brnch.
REQ-014 valid_out  output  1  writeback outputs valid this cycle.
REQ-015 readData, ALUresultMEM  output  32 each  load data; forwarded ALU result.
REQ-016 writeRegMEM  output  5; RegWriteMEM, MemtoRegMEM  output  1 each  forwarded to writeback.
REQ-017 dmem_req, dmem_we  output  1 each  memory request; write enable.
REQ-018 dmem_addr, dmem_wdata  output  32 each  word address (bits[1:0]=00), store data.
REQ-019 dmem_rdata  input  32; dmem_ack  input  1  read data; request completion.
REQ-020 align_err, bus_err  output  1 each  single-cycle error pulses.

Function
REQ-021 FSM states IDLE, WAIT; stall SHALL equal (state==WAIT), combinational from state.
REQ-022 IDLE, valid_in=1: instruction accepted at the clock edge; at most one instruction in flight.
REQ-023 Accepted instruction with Branch=1: PCSrc=zero and branchTarget=brnch registered, asserted one cycle after acceptance for exactly one cycle; PCSrc=0 otherwise.
REQ-024 Accepted, MemRead=0 and MemWrite=0: valid_out=1 one cycle later with ALUresultMEM, writeRegMEM, RegWriteMEM, MemtoRegMEM from inputs; readData holds previous value; state stays IDLE.
REQ-025 Accepted, MemRead or MemWrite, ALUresult[1:0]==00: next cycle state=WAIT, dmem_req=1, dmem_addr=ALUresult, dmem_wdata=rdData2, dmem_we=MemWrite (MemWrite wins if both set).
REQ-026 Accepted memory op with ALUresult[1:0]!=00: no request; align_err pulses one cycle later; valid_out stays 0 for that instruction; state stays IDLE.
REQ-027 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL stay stable until dmem_ack sampled high or timeout.
REQ-028 WAIT, dmem_ack=1: next cycle dmem_req=0, state=IDLE, valid_out=1 for one cycle; readData=dmem_rdata captured at the ack edge for reads; forwarded fields from accepted instruction.
REQ-029 Cycle counter clears on entry to WAIT and increments each WAIT cycle without ack; when it reaches TIMEOUT with no ack: next cycle dmem_req=0, bus_err pulses, valid_out=0, state=IDLE.
REQ-030 dmem_ack in the same cycle as timeout count reaching TIMEOUT: ack wins, normal completion, no bus_err.
REQ-031 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-032 valid_out, PCSrc, align_err, bus_err are single-cycle pulses per instruction; never two completions for one instruction.
REQ-033 Back-to-back non-memory instructions: one accepted per cycle, valid_out high every cycle.

Reset
REQ-034 rst=1 at clock edge: state=IDLE, counter=0; stall, PCSrc, valid_out, dmem_req, dmem_we, align_err, bus_err=0; branchTarget, readData, ALUresultMEM, dmem_addr, dmem_wdata=0; writeRegMEM=0; RegWriteMEM, MemtoRegMEM=0.
REQ-035 Reset during WAIT: request abandoned, dmem_req=0 next cycle, no valid_out, no bus_err; late ack ignored.
REQ-036 valid_in sampled during rst SHALL be ignored.

Verification
REQ-037 Load: ALUresult=0x100, MemRead=1, writeReg=5; ack 3 cycles after req with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x100, dmem_we=0, valid_out one pulse, readData=0xDEADBEEF, writeRegMEM=5.
REQ-038 Store: ALUresult=0x204, rdData2=0x12345678, MemWrite=1, ack same cycle req first seen -> dmem_we=1, dmem_wdata=0x12345678, stall 1 cycle, valid_out one pulse.
REQ-039 Misaligned load ALUresult=0x102 -> no dmem_req, align_err one pulse, valid_out=0.
REQ-040 No ack, TIMEOUT=16 -> dmem_req high 16 cycles, then dropped, bus_err one pulse, next instruction accepted.
REQ-041 Branch=1, zero=1, brnch=0x40 followed by 4 back-to-back R-type -> PCSrc=1, branchTarget=0x40 for one cycle; valid_out high 5 consecutive cycles.
REQ-042 rst asserted in 2nd WAIT cycle, ack arrives after reset -> outputs at reset values, no valid_out, no bus_err.
